maxnet_driver: RTL and testbench
================================

MAXNET_DRIVER -- requirements
Module: maxnet_driver

Interface
REQ-001 Parameter RESULT_W, default 32: width of the maxnet result word.
REQ-002 Parameter TIMEOUT, default 255: maximum WAIT cycles before a job is abandoned; legal range 1..65535.
REQ-003 Parameter DEPTH, default 4: result FIFO entries; power of two, at least 2.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  job request from the host.
REQ-007 req_ready  output  1  driver can accept a job this cycle.
REQ-008 mn_start  output  1  start pulse to the maxnet engine.
REQ-009 mn_done  input  1  engine completion indication.
REQ-010 mn_result  input  RESULT_W  engine result; valid when mn_done=1.
REQ-011 res_valid  output  1  FIFO head holds a result.
REQ-012 res_ready  input  1  host consumes the FIFO head.
REQ-013 res_data  output  RESULT_W  FIFO head result word.
REQ-014 res_timeout  output  1  FIFO head entry was produced by a timeout.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 job_count  output  8  completed jobs counter, including timeouts; wraps from 255 to 0.

Function
REQ-017 FSM states SHALL be IDLE, START, WAIT and STORE.
REQ-018 req_ready SHALL be 1 only in IDLE with FIFO occupancy < DEPTH.
REQ-019 IDLE->START occurs on the edge where req_valid & req_ready; otherwise stay in IDLE.
REQ-020 In START, mn_start=1 for exactly one cycle; START->WAIT is unconditional; mn_start=0 in all other states.
REQ-021 On WAIT entry, the wait counter (16 bits) SHALL be 0 and SHALL increment each WAIT cycle.
REQ-022 WAIT with mn_done=1 SHALL capture mn_result with timeout flag 0, then go to STORE.
REQ-023 WAIT with mn_done=0 and counter == TIMEOUT-1 SHALL capture data 0 with timeout flag 1, then go to STORE.
REQ-024 mn_done=1 in the same cycle as the timeout condition: done wins, the result is captured, and the timeout flag is 0.
REQ-025 mn_done SHALL be ignored in IDLE, START and STORE.
REQ-026 In STORE, push {flag, captured data} into the FIFO, increment job_count, then go to IDLE.
- A push never overflows, because acceptance requires free space and at most one job is in flight.
REQ-027 FIFO SHALL be first-word fall-through.
- res_valid = not empty; res_data and res_timeout show the head entry.
- Pop on res_valid & res_ready.
REQ-028 Simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
- Pop when empty has no effect.
- Read and write pointers wrap modulo DEPTH.
REQ-029 Latency requirements:
- Accept edge at cycle N gives mn_start high in cycle N+1.
- mn_done sampled at edge K gives res_valid high by cycle K+2 when the FIFO was empty.
REQ-030 Maximum throughput SHALL be one job per (4 + engine latency) cycles; back-to-back jobs SHALL re-enter IDLE for one cycle.

Reset
REQ-031 Asserting rst SHALL immediately force the following, independent of clk:
- state IDLE, wait counter 0, job_count 0
- FIFO empty, mn_start 0, busy 0, res_valid 0, res_data 0, res_timeout 0
REQ-032 Reset during START, WAIT or STORE SHALL abandon the job: no FIFO entry, no job_count increment.
REQ-033 After rst deasserts, req_ready SHALL be 1 in the first cycle.

Verification
REQ-034 Normal job: req_valid pulse; mn_done=1 with mn_result=0x0000_0007 three cycles after mn_start -> one mn_start pulse; res_valid, res_data=0x7, res_timeout=0, job_count=1.
REQ-035 Timeout with TIMEOUT=8 and mn_done held 0 -> exactly 8 WAIT cycles; entry res_data=0, res_timeout=1; busy falls.
REQ-036 Full FIFO: DEPTH=4, res_ready=0, 4 jobs complete -> req_ready=0 and a 5th req_valid is not accepted; one pop -> req_ready returns to 1.
REQ-037 Race: mn_done=1 on the TIMEOUT-1 cycle with result 0xA5 -> res_data=0xA5, res_timeout=0.
REQ-038 Reset in WAIT: assert rst mid-WAIT, then release -> FIFO empty, job_count=0; a late mn_done is ignored; a new job completes normally.
REQ-039 Ordering: 3 jobs with results 1, 2, 3, popping with res_ready toggled so that push and pop coincide -> output order 1, 2, 3, and job_count=3.

Source files
------------

// File: rtl/maxnet_if.sv
// Host/engine-facing signal bundle of the maxnet driver.
// The slave modport is the driver; master is whatever drives host requests and the engine.
interface maxnet_if #(
    parameter int unsigned RESULT_W = 32
);
    logic                req_valid;
    logic                req_ready;
    logic                mn_start;
    logic                mn_done;
    logic [RESULT_W-1:0] mn_result;
    logic                res_valid;
    logic                res_ready;
    logic [RESULT_W-1:0] res_data;
    logic                res_timeout;
    logic                busy;
    logic [7:0]          job_count;

    modport master (
        output req_valid,
        input  req_ready,
        input  mn_start,
        output mn_done,
        output mn_result,
        input  res_valid,
        output res_ready,
        input  res_data,
        input  res_timeout,
        input  busy,
        input  job_count
    );

    modport slave (
        input  req_valid,
        output req_ready,
        output mn_start,
        input  mn_done,
        input  mn_result,
        output res_valid,
        input  res_ready,
        output res_data,
        output res_timeout,
        output busy,
        output job_count
    );
endinterface

// File: rtl/maxnet_driver.sv
// Runs one maxnet engine job at a time with a completion timeout and queues
// each outcome (result or timeout marker) in a first-word fall-through FIFO.
module maxnet_driver #(
    parameter int unsigned RESULT_W = 32,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned DEPTH    = 4
) (
    input logic     clk,
    input logic     rst,
    maxnet_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StStart, StWait, StStore} state_t;

    state_t              state_q;
    logic [15:0]         wait_q;
    logic                mn_start_q;
    logic                busy_q;
    logic [RESULT_W-1:0] cap_data_q;
    logic                cap_to_q;
    logic [7:0]          job_count_q;

    logic [RESULT_W:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]    wptr_q;
    logic [PTR_W-1:0]    rptr_q;
    logic [CNT_W-1:0]    count_q;

    logic              push;
    logic              pop;
    logic              req_ready;
    logic              res_valid;
    logic [RESULT_W:0] head;

    assign push      = (state_q == StStore);
    assign res_valid = (count_q != '0);
    assign pop       = res_valid & bus.res_ready;
    assign req_ready = (state_q == StIdle) && (count_q < CNT_W'(DEPTH));
    assign head      = mem_q[rptr_q];

    assign bus.req_ready   = req_ready;
    assign bus.mn_start    = mn_start_q;
    assign bus.busy        = busy_q;
    assign bus.job_count   = job_count_q;
    assign bus.res_valid   = res_valid;
    // Head is gated so an empty FIFO reads as zero without resetting the storage.
    assign bus.res_data    = res_valid ? head[RESULT_W-1:0] : '0;
    assign bus.res_timeout = res_valid & head[RESULT_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            wait_q      <= '0;
            mn_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            cap_data_q  <= '0;
            cap_to_q    <= 1'b0;
            job_count_q <= '0;
        end else begin
            mn_start_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.req_valid && req_ready) begin
                        state_q    <= StStart;
                        mn_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                StStart: begin
                    state_q <= StWait;
                    wait_q  <= '0;
                end
                StWait: begin
                    // Completion takes priority over a timeout in the same cycle.
                    if (bus.mn_done) begin
                        cap_data_q <= bus.mn_result;
                        cap_to_q   <= 1'b0;
                        state_q    <= StStore;
                    end else if (wait_q == 16'(TIMEOUT - 1)) begin
                        cap_data_q <= '0;
                        cap_to_q   <= 1'b1;
                        state_q    <= StStore;
                    end else begin
                        wait_q <= wait_q + 16'd1;
                    end
                end
                StStore: begin
                    job_count_q <= job_count_q + 8'd1;
                    busy_q      <= 1'b0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PTR_W'(1);
            if (pop)  rptr_q <= rptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {cap_to_q, cap_data_q};
    end
endmodule

// File: tb/tb_maxnet_driver.sv
// Bench for maxnet_driver: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against a job-level reference model.
module tb_maxnet_driver;
    localparam int TIMEOUT = 8;
    localparam int DEPTH   = 4;

    logic clk;
    logic rst;
    maxnet_if #(.RESULT_W(32)) bus ();

    maxnet_driver #(.RESULT_W(32), .TIMEOUT(TIMEOUT), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    typedef struct packed {
        logic        to;
        logic [31:0] d;
    } ent_t;

    // Reference model: a queue for the FIFO and a per-job age counted from the accept edge.
    ent_t        mq[$];
    bit          m_in_job = 0;
    bit          m_store  = 0;
    int          m_age    = 0;
    logic [31:0] m_cap    = '0;
    bit          m_cap_to = 0;
    int          m_jc     = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit   full;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_in_job = 0;
            m_store  = 0;
            m_age    = 0;
            m_jc     = 0;
            return;
        end
        full = (mq.size() >= DEPTH);
        if (mq.size() > 0 && bus.res_ready) void'(mq.pop_front());
        if (!m_in_job) begin
            if (bus.req_valid && !full) begin
                m_in_job = 1;
                m_age    = 1;
                m_store  = 0;
            end
        end else if (m_store) begin
            e.to = m_cap_to;
            e.d  = m_cap;
            mq.push_back(e);
            m_jc     = (m_jc + 1) % 256;
            m_in_job = 0;
            m_store  = 0;
        end else if (m_age >= 2) begin
            if (bus.mn_done) begin
                m_cap    = bus.mn_result;
                m_cap_to = 0;
                m_store  = 1;
            end else if (m_age - 2 == TIMEOUT - 1) begin
                m_cap    = '0;
                m_cap_to = 1;
                m_store  = 1;
            end else begin
                m_age++;
            end
        end else begin
            m_age++;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check1("cyc_busy", bus.busy, m_in_job);
            check1("cyc_mn_start", bus.mn_start, m_in_job && !m_store && m_age == 1);
            check1("cyc_req_ready", bus.req_ready, !m_in_job && mq.size() < DEPTH);
            check1("cyc_res_valid", bus.res_valid, mq.size() > 0);
            check32("cyc_res_data", bus.res_data, mq.size() > 0 ? mq[0].d : 32'h0);
            check1("cyc_res_timeout", bus.res_timeout, mq.size() > 0 ? mq[0].to : 1'b0);
            check32("cyc_job_count", 32'(bus.job_count), 32'(m_jc));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept, wait lat cycles after the start cycle, complete; returns in the following IDLE cycle.
    task automatic run_job(input int lat, input logic [31:0] val, input bit pop,
                           output logic [31:0] popped);
        bus.req_valid = 1;
        step();
        bus.req_valid = 0;
        check1("start_pulse", bus.mn_start, 1'b1);
        step();
        check1("start_one_cycle", bus.mn_start, 1'b0);
        repeat (lat - 1) step();
        bus.mn_done   = 1;
        bus.mn_result = val;
        step();
        bus.mn_done   = 0;
        bus.res_ready = pop;
        popped        = bus.res_data;
        step();
        bus.res_ready = 0;
    endtask

    task automatic pop_one(output logic [31:0] d);
        bus.res_ready = 1;
        d = bus.res_data;
        step();
        bus.res_ready = 0;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] seq[3];
        int          lat;

        rst           = 0;
        bus.req_valid = 0;
        bus.mn_done   = 0;
        bus.mn_result = '0;
        bus.res_ready = 0;
        #1 rst = 1;
        #1 cmp_en = 1;
        check1("rst_async_busy", bus.busy, 1'b0);
        check1("rst_async_res_valid", bus.res_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check1("rst_req_ready", bus.req_ready, 1'b1);
        check32("rst_job_count", 32'(bus.job_count), 32'd0);
        check32("rst_res_data", bus.res_data, 32'd0);

        // Normal job, done three cycles after the start pulse.
        run_job(3, 32'h7, 0, d);
        check1("norm_res_valid", bus.res_valid, 1'b1);
        check32("norm_res_data", bus.res_data, 32'h7);
        check1("norm_res_timeout", bus.res_timeout, 1'b0);
        check32("norm_job_count", 32'(bus.job_count), 32'd1);
        pop_one(d);

        // Timeout: start cycle, 8 WAIT cycles, STORE, then res_valid.
        bus.req_valid = 1;
        step();
        bus.req_valid = 0;
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (bus.res_valid) begin
                lat = i;
                break;
            end
        end
        check32("to_latency", 32'(lat), 32'd10);
        check32("to_res_data", bus.res_data, 32'd0);
        check1("to_res_timeout", bus.res_timeout, 1'b1);
        check1("to_busy_fell", bus.busy, 1'b0);
        check32("to_job_count", 32'(bus.job_count), 32'd2);
        pop_one(d);

        // Done arrives on the last permitted WAIT cycle.
        run_job(TIMEOUT, 32'hA5, 0, d);
        check32("race_res_data", bus.res_data, 32'hA5);
        check1("race_res_timeout", bus.res_timeout, 1'b0);
        pop_one(d);

        // Fill the FIFO, then a 5th request must be refused until one pop.
        for (int j = 0; j < DEPTH; j++) run_job(1, 32'(100 + j), 0, d);
        check1("full_req_ready", bus.req_ready, 1'b0);
        check32("full_model_depth", 32'(mq.size()), 32'd4);
        bus.req_valid = 1;
        for (int j = 0; j < 3; j++) begin
            step();
            check1("full_no_start", bus.mn_start, 1'b0);
        end
        bus.req_valid = 0;
        pop_one(d);
        check32("full_pop_head", d, 32'd100);
        check1("full_ready_back", bus.req_ready, 1'b1);
        for (int j = 0; j < 3; j++) pop_one(d);
        check1("full_drained", bus.res_valid, 1'b0);

        // Reset in WAIT abandons the job; a late done is ignored.
        bus.req_valid = 1;
        step();
        bus.req_valid = 0;
        repeat (2) step();
        rst = 1;
        #1;
        check1("rw_busy", bus.busy, 1'b0);
        check32("rw_job_count", 32'(bus.job_count), 32'd0);
        @(posedge clk);
        #1 rst = 0;
        check1("rw_req_ready", bus.req_ready, 1'b1);
        bus.mn_done   = 1;
        bus.mn_result = 32'hDEAD;
        step();
        bus.mn_done = 0;
        step();
        check1("rw_late_done_ignored", bus.res_valid, 1'b0);
        run_job(2, 32'h55, 0, d);
        check32("rw_new_job", bus.res_data, 32'h55);
        check32("rw_new_count", 32'(bus.job_count), 32'd1);

        // Ordering with push and pop in the same cycle.
        rst = 1;
        step();
        rst = 0;
        run_job(1, 32'd1, 0, d);
        run_job(2, 32'd2, 1, seq[0]);
        check32("ord_after_swap", bus.res_data, 32'd2);
        run_job(1, 32'd3, 1, seq[1]);
        pop_one(seq[2]);
        check32("ord_0", seq[0], 32'd1);
        check32("ord_1", seq[1], 32'd2);
        check32("ord_2", seq[2], 32'd3);
        check1("ord_empty", bus.res_valid, 1'b0);
        check32("ord_job_count", 32'(bus.job_count), 32'd3);

        // Random traffic, including spurious done pulses and rare resets.
        for (int i = 0; i < 4000; i++) begin
            bus.req_valid = ($urandom_range(0, 2) == 0);
            bus.mn_done   = ($urandom_range(0, 5) == 0);
            bus.mn_result = $urandom;
            bus.res_ready = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1499) == 0) rst = 1;
            step();
            rst = 0;
        end
        bus.req_valid = 0;
        bus.mn_done   = 0;
        bus.res_ready = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
